// File: rtl/cs_stream_feeder.sv
// Source-side feeder for the CS block: buffers host samples in a FIFO, streams one per clock into CS X,
// and captures CS Y only when every slot of the CS window holds a genuine sample.
module cs_stream_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             run,
    output logic [7:0]       x_out,
    input  logic [9:0]       y_in,
    output logic [9:0]       y_out,
    output logic             y_valid,
    output logic             underrun,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [3:0]       prime_cnt, prime_cnt_next;
    logic             underrun_next;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop;

    logic             xv;
    logic [8:0]       vwin;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign pop        = run && !empty && (state != IDLE);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Full is judged before any same-cycle pop, so a pop never frees room for a push in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // vwin trails x_out by one edge, exactly as CS captures X, so &vwin marks a window of real samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_out    <= '0;
            xv       <= 1'b0;
            vwin     <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            x_out    <= pop ? mem[rd_ptr] : 8'h00;
            xv       <= pop;
            vwin     <= {vwin[7:0], xv};
            underrun <= underrun_next;
            if (&vwin) begin
                y_out   <= y_in;
                y_valid <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prime_cnt <= '0;
        end else begin
            state     <= state_next;
            prime_cnt <= prime_cnt_next;
        end
    end

    // Outside IDLE, run=1 with data always pops, so the prime count only clears on an empty FIFO.
    always_comb begin
        state_next     = state;
        prime_cnt_next = prime_cnt;
        underrun_next  = 1'b0;
        if (!run) begin
            state_next     = IDLE;
            prime_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = PRIME;
                end
                PRIME: begin
                    if (empty) begin
                        underrun_next  = 1'b1;
                        prime_cnt_next = '0;
                    end else if (prime_cnt == 4'd8) begin
                        state_next     = STREAM;
                        prime_cnt_next = '0;
                    end else begin
                        prime_cnt_next = prime_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (empty) begin
                        underrun_next  = 1'b1;
                        state_next     = PRIME;
                        prime_cnt_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
